// File: rtl/wb_interconnect_reg.sv
// Registered Wishbone decode of one upstream transaction onto team slots 1..NUM_TEAMS, LA or GPIO control.
// Latency: slave strobe 1 cycle after the request edge, wbs_ack_o 1 cycle after the slave ack; unmapped acks in 1 cycle.
// Backpressure: waits in BUSY for the selected ack or a cyc drop; with WB_TIMEOUT_EN a stalled slave is forced to DONE.
module wb_interconnect_reg #(
    parameter int          NUM_TEAMS      = 12,
    parameter logic [7:0]  DESIGN_BASE    = 8'h30,
    parameter logic [15:0] LA_BASE        = 16'h3100,
    parameter logic [15:0] GPIO_BASE      = 16'h3200,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic [31:0]                 wbs_adr_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic [NUM_TEAMS:0]          designs_stb,
    output logic                        la_control_stb,
    output logic                        gpio_control_stb,
    input  logic [32*(NUM_TEAMS+1)-1:0] designs_wbs_dat_o_flat,
    input  logic [31:0]                 la_control_dat_o,
    input  logic [31:0]                 gpio_control_dat_o,
    input  logic [NUM_TEAMS:0]          designs_ack_o,
    input  logic                        la_control_ack_o,
    input  logic                        gpio_control_ack_o,
    output logic [7:0]                  timeout_count_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {TGT_TEAM, TGT_LA, TGT_GPIO} tgt_t;

    localparam logic [7:0] MAX_TEAM = 8'(NUM_TEAMS);

    state_t      state_q, state_d;
    tgt_t        tgt_q, tgt_d;
    logic [7:0]  team_q, team_d;
    logic [31:0] dat_q, dat_d;

    logic        req;
    logic [7:0]  adr_team;
    logic        is_team, is_la, is_gpio;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        expire;
    logic        tmo_event;

    // Low address bits only matter to the slaves themselves.
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[15:0];

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign adr_team = wbs_adr_i[23:16];
    assign is_team  = (wbs_adr_i[31:24] == DESIGN_BASE) && (adr_team != 8'd0) && (adr_team <= MAX_TEAM);
    assign is_la    = (wbs_adr_i[31:16] == LA_BASE);
    assign is_gpio  = (wbs_adr_i[31:16] == GPIO_BASE);

    assign wbs_ack_o = (state_q == DONE);
    assign wbs_dat_o = dat_q;

    // Mux the registered target's ack and read data; other slaves' acks never reach the FSM.
    always_comb begin
        sel_ack = 1'b0;
        sel_dat = '0;
        case (tgt_q)
            TGT_LA: begin
                sel_ack = la_control_ack_o;
                sel_dat = la_control_dat_o;
            end
            TGT_GPIO: begin
                sel_ack = gpio_control_ack_o;
                sel_dat = gpio_control_dat_o;
            end
            default: begin
                for (int n = 0; n <= NUM_TEAMS; n++) begin
                    if (team_q == 8'(n)) begin
                        sel_ack = designs_ack_o[n];
                        sel_dat = designs_wbs_dat_o_flat[32*n +: 32];
                    end
                end
            end
        endcase
    end

    // Strobes follow the live upstream request, only in BUSY; slot 0 is never driven.
    always_comb begin
        designs_stb      = '0;
        la_control_stb   = 1'b0;
        gpio_control_stb = 1'b0;
        if (state_q == BUSY) begin
            la_control_stb   = (tgt_q == TGT_LA) && req;
            gpio_control_stb = (tgt_q == TGT_GPIO) && req;
            for (int n = 1; n <= NUM_TEAMS; n++) begin
                designs_stb[n] = (tgt_q == TGT_TEAM) && (team_q == 8'(n)) && req;
            end
        end
    end

    // Next-state: decode in IDLE, wait in BUSY (abort beats ack beats timeout), one-cycle DONE.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        team_d    = team_q;
        dat_d     = dat_q;
        tmo_event = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    team_d = adr_team;
                    if (is_team) begin
                        tgt_d   = TGT_TEAM;
                        state_d = BUSY;
                    end else if (is_la) begin
                        tgt_d   = TGT_LA;
                        state_d = BUSY;
                    end else if (is_gpio) begin
                        tgt_d   = TGT_GPIO;
                        state_d = BUSY;
                    end else begin
                        dat_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (sel_ack) begin
                    dat_d   = sel_dat;
                    state_d = DONE;
                end else if (expire) begin
                    dat_d     = TIMEOUT_DATA;
                    state_d   = DONE;
                    tmo_event = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and capture registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            tgt_q   <= TGT_TEAM;
            team_q  <= 8'd0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            team_q  <= team_d;
            dat_q   <= dat_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    tmo_q, tmo_d;

    assign expire          = (cnt_q == CNT_LAST);
    assign timeout_count_o = tmo_q;

    // Busy-cycle counter restarts on BUSY entry; timeout tally saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && state_d == BUSY) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
        tmo_d = tmo_q;
        if (tmo_event && tmo_q != 8'hFF) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    // Timeout counter registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
            tmo_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo      = ^32'(TIMEOUT_CYCLES);
    assign expire          = 1'b0;
    assign timeout_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_wb_interconnect_reg.sv
module tb_wb_interconnect_reg;
    localparam int NT   = 12;
    localparam int TMO  = 8;
    localparam int LA   = 100;
    localparam int GPIO = 101;
`ifdef WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  cyc, stb;
    logic [31:0]           adr;
    logic                  ack_o;
    logic [31:0]           dat_o;
    logic [NT:0]           d_stb;
    logic                  la_stb, gpio_stb;
    logic [32*(NT+1)-1:0]  d_dat;
    logic [31:0]           la_dat, gpio_dat;
    logic [NT:0]           d_ack;
    logic                  la_ack, gpio_ack;
    logic [7:0]            tmo_cnt;
    logic [31:0]           strobes;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  exp_tmo = 8'd0;

    always #5 clk = ~clk;

    assign strobes = {17'd0, gpio_stb, la_stb, d_stb};

    wb_interconnect_reg #(
        .NUM_TEAMS      (NT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i               (clk),
        .wb_rst_i               (rst),
        .wbs_cyc_i              (cyc),
        .wbs_stb_i              (stb),
        .wbs_adr_i              (adr),
        .wbs_ack_o              (ack_o),
        .wbs_dat_o              (dat_o),
        .designs_stb            (d_stb),
        .la_control_stb         (la_stb),
        .gpio_control_stb       (gpio_stb),
        .designs_wbs_dat_o_flat (d_dat),
        .la_control_dat_o       (la_dat),
        .gpio_control_dat_o     (gpio_dat),
        .designs_ack_o          (d_ack),
        .la_control_ack_o       (la_ack),
        .gpio_control_ack_o     (gpio_ack),
        .timeout_count_o        (tmo_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_acks;
        d_ack    = '0;
        la_ack   = 1'b0;
        gpio_ack = 1'b0;
    endtask

    // tgt: 1..NT team slot, LA, GPIO, or -1 for unmapped; d = BUSY cycle in which the slave acks.
    task automatic txn(input string tag, input logic [31:0] a, input int tgt, input int d,
                       input logic [31:0] sdat);
        logic [31:0] exp_stb;
        logic [31:0] exp_dat;
        int          exp_k;
        int          k;
        bit          tmo;
        bit          seen;
        exp_stb = 32'd0;
        if (tgt >= 1 && tgt <= NT) begin
            exp_stb[tgt] = 1'b1;
            d_dat[32*tgt +: 32] = sdat;
        end else if (tgt == LA) begin
            exp_stb[NT+1] = 1'b1;
            la_dat = sdat;
        end else if (tgt == GPIO) begin
            exp_stb[NT+2] = 1'b1;
            gpio_dat = sdat;
        end
        tmo     = TMO_EN && (tgt != -1) && (d > TMO - 1);
        exp_k   = (tgt == -1) ? -1 : (tmo ? TMO - 1 : d);
        exp_dat = (tgt == -1) ? 32'd0 : (tmo ? 32'hDEAD_BEEF : sdat);
        exp_q.push_back(exp_dat);

        cyc = 1'b1;
        stb = 1'b1;
        adr = a;
        #1;
        chk({tag, "_idle_stb"}, strobes, 32'd0);
        tick;
        adr  = 32'h300B_0000;
        seen = (ack_o === 1'b1);
        k    = -1;
        while (!seen && k < 40) begin
            k++;
            chk({tag, "_stb"}, strobes, exp_stb);
            if (tgt != GPIO) gpio_ack = (k == 0) && (d > 0);
            if (k == d) begin
                if (tgt >= 1 && tgt <= NT) d_ack[tgt] = 1'b1;
                else if (tgt == LA)        la_ack = 1'b1;
                else if (tgt == GPIO)      gpio_ack = 1'b1;
            end
            tick;
            clear_acks;
            seen = (ack_o === 1'b1);
        end
        if (!seen) begin
            chk({tag, "_ack"}, 32'(ack_o), 32'd1);
            void'(exp_q.pop_front());
        end else begin
            chk({tag, "_lat"}, 32'(k), 32'(exp_k));
            chk({tag, "_dat"}, dat_o, exp_q.pop_front());
        end
        chk({tag, "_done_stb"}, strobes, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        tick;
        chk({tag, "_ack_once"}, 32'(ack_o), 32'd0);
        chk({tag, "_hold"}, dat_o, exp_dat);
        if (tmo && exp_tmo != 8'hFF) exp_tmo++;
        chk({tag, "_tmo"}, 32'(tmo_cnt), 32'(exp_tmo));
    endtask

    initial begin
        bit any_ack;
        rst  = 1'b1;
        cyc  = 1'b0;
        stb  = 1'b0;
        adr  = 32'd0;
        clear_acks;
        la_dat   = 32'h1A1A_0000;
        gpio_dat = 32'h6B6B_0000;
        for (int n = 0; n <= NT; n++) d_dat[32*n +: 32] = 32'hA000_0000 + 32'(n);
        tick;
        tick;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_stb", strobes, 32'd0);
        chk("rst_tmo", 32'(tmo_cnt), 32'd0);
        rst = 1'b0;
        tick;

        txn("team3", 32'h3003_0010, 3, 0, 32'h1234_5678);
        txn("unm_s0", 32'h3000_0000, -1, 0, 32'h0);
        txn("unm_s13", 32'h300D_0000, -1, 0, 32'h0);
        txn("unm_33", 32'h3300_0000, -1, 0, 32'h0);
        txn("team12", 32'h300C_0004, 12, 3, 32'hC0DE_000C);
        txn("la", 32'h3100_0008, LA, 1, 32'h5A5A_1111);

        if (TMO_EN) begin
            txn("slot5_tmo", 32'h3005_0000, 5, 1000, 32'h5555_5555);
        end else begin
            cyc = 1'b1;
            stb = 1'b1;
            adr = 32'h3005_0000;
            any_ack = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                tick;
                if (ack_o !== 1'b0) any_ack = 1'b1;
            end
            chk("slot5_hang", 32'(any_ack), 32'd0);
            cyc = 1'b0;
            stb = 1'b0;
            tick;
            chk("slot5_abort_stb", strobes, 32'd0);
        end

        txn("gpio_exp", 32'h3200_0000, GPIO, TMO - 1, 32'h6767_0707);

        // LA abort in the second BUSY cycle
        cyc = 1'b1;
        stb = 1'b1;
        adr = 32'h3100_0000;
        tick;
        chk("ab_stb0", strobes, 32'h0000_2000);
        tick;
        chk("ab_stb1", strobes, 32'h0000_2000);
        cyc = 1'b0;
        stb = 1'b0;
        #1;
        chk("ab_stb_fall", strobes, 32'd0);
        tick;
        chk("ab_noack", 32'(ack_o), 32'd0);
        la_ack = 1'b1;
        tick;
        clear_acks;
        chk("ab_stale", 32'(ack_o), 32'd0);
        chk("ab_hold", dat_o, 32'h6767_0707);
        txn("after_ab", 32'h3001_0000, 1, 0, 32'h0101_0101);
        txn("b2b", 32'h3002_0000, 2, 2, 32'h0202_0202);

        // Reset during BUSY
        cyc = 1'b1;
        stb = 1'b1;
        adr = 32'h3007_0000;
        tick;
        chk("r_busy_stb", strobes, 32'h0000_0080);
        rst = 1'b1;
        tick;
        chk("r_ack", 32'(ack_o), 32'd0);
        chk("r_stb", strobes, 32'd0);
        chk("r_tmo", 32'(tmo_cnt), 32'd0);
        chk("r_dat", dat_o, 32'd0);
        cyc = 1'b0;
        stb = 1'b0;
        rst = 1'b0;
        exp_tmo = 8'd0;
        d_ack[7] = 1'b1;
        tick;
        clear_acks;
        chk("r_stale0", 32'(ack_o), 32'd0);
        tick;
        chk("r_stale1", 32'(ack_o), 32'd0);
        txn("post_rst", 32'h3007_0000, 7, 0, 32'h7777_0007);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_interconnect_reg.md
# wb_interconnect_reg

Registered, parametrised Wishbone slave-side interconnect for the user area. It decodes one upstream Wishbone classic transaction onto one of NUM_TEAMS team designs, the LA control block or the GPIO control block. It also terminates transactions to unmapped addresses and, optionally, to stalled slaves, so the management SoC can never hang on a bad address. It sits between the Caravel user-project Wishbone port and the per-design and control slaves.

## Interface
- NUM_TEAMS, 12: number of team slots; teams are 1..NUM_TEAMS, slot 0 is never mapped; max 255.
- DESIGN_BASE, 8'h30: value of adr[31:24] for the team region; team index is adr[23:16].
- LA_BASE, 16'h3100: value of adr[31:16] for LA control.
- GPIO_BASE, 16'h3200: value of adr[31:16] for GPIO control.
- TIMEOUT_CYCLES, 255: cycles spent in BUSY before a forced termination; minimum 2.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on timeout.

- wb_clk_i  in  1  sole clock; everything is on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i, wbs_stb_i  in  1 each  upstream cycle and strobe.
- wbs_adr_i  in  32  upstream address.
- wbs_ack_o  out  1  upstream acknowledge.
- wbs_dat_o  out  32  upstream read data.
- designs_stb  out  NUM_TEAMS+1  per-slot strobe; bit 0 is always 0.
- la_control_stb, gpio_control_stb  out  1 each  control-block strobes.
- designs_wbs_dat_o_flat  in  32*(NUM_TEAMS+1)  slot n read data at [32n +: 32].
- la_control_dat_o, gpio_control_dat_o  in  32 each.
- designs_ack_o  in  NUM_TEAMS+1; la_control_ack_o, gpio_control_ack_o  in  1 each.
- timeout_count_o  out  8  saturating count of timeouts (0 when the timeout feature is compiled out).

## Operation
- FSM has three states: IDLE, BUSY, DONE. Reset puts it in IDLE.
- **IDLE:** when wbs_cyc_i & wbs_stb_i, register a target select from wbs_adr_i.
  - The target is one of: team n (1 ≤ n ≤ NUM_TEAMS), LA, GPIO, or UNMAPPED.
  - Mapped target → BUSY. UNMAPPED → DONE with response data 0.
- **BUSY:** the selected strobe output = wbs_stb_i & wbs_cyc_i. All other strobes are 0.
  - Selected slave ack = 1 → capture that slave's dat_o, go to DONE.
  - wbs_cyc_i = 0 → abort to IDLE. No ack is issued and nothing is captured.
- **DONE:** wbs_ack_o = 1 and wbs_dat_o = captured data, for exactly one cycle. Then go to IDLE. All strobes are 0 in this state.
- wbs_dat_o is held at the last captured value outside DONE.
- Acks from unselected slaves are ignored in every state, as are acks arriving in IDLE or DONE.
- The address is sampled only in IDLE. Address changes during BUSY are ignored.

## Timing
- Reset values:
  - wbs_ack_o = 0 and wbs_dat_o = 0.
  - All strobes = 0.
  - timeout_count_o = 0.
  - Timeout counter = 0.
- Reset asserted mid-transaction returns the FSM to IDLE on that edge. No ack is issued.
- Mapped-target latency, counting the request-sampling edge as E0:
  - Slave strobe is high in the cycle after E0.
  - If the slave acks in that cycle (sampled at E1), wbs_ack_o is high in the cycle after E1.
  - Minimum request-to-ack is therefore 2 cycles. In general, ack_o follows the slave ack by 1 cycle.
- Unmapped latency: wbs_ack_o is high in the cycle after E0 (1 cycle).
- Back-to-back: a new request may be sampled in the cycle immediately after the DONE cycle.
- Timeout counter: cleared on entering BUSY, increments each BUSY cycle. Width is $clog2(TIMEOUT_CYCLES+1).

## Configuration
- WB_TIMEOUT_EN defined:
  - In BUSY, a counter reaching TIMEOUT_CYCLES-1 with no slave ack forces DONE with data TIMEOUT_DATA.
  - timeout_count_o increments, saturating at 255.
  - A slave ack in the same cycle as expiry wins: the slave's data is returned and the count is unchanged.
- WB_TIMEOUT_EN undefined:
  - BUSY waits indefinitely for the ack or for wbs_cyc_i to drop.
  - The counter logic is absent and timeout_count_o is tied to 0.

## Test plan
- Team 3, adr 0x3003_0010: slot 3 acks in its first strobe cycle with 0x1234_5678 → designs_stb = 13'b0_0000_0000_1000 for 1 cycle; wbs_ack_o high 2 cycles after the request with dat 0x1234_5678.
- Unmapped adr 0x3000_0000 (slot 0), 0x300D_0000 (slot 13) and 0x3300_0000 → all strobes 0; ack 1 cycle later with dat 0.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slot 5 never acks → ack after exactly 8 BUSY cycles with 0xDEAD_BEEF; timeout_count_o goes 0→1. With the macro undefined → no ack for 1000 cycles.
- GPIO access with gpio_control_ack_o asserted in the same cycle the counter expires → dat = GPIO data; timeout_count_o unchanged.
- LA access: drop wbs_cyc_i in the 2nd BUSY cycle → la_control_stb falls on the same cycle; no ack; the next request is accepted normally.
- Assert wb_rst_i during BUSY → state IDLE next cycle; ack_o, strobes and timeout_count_o are 0; a stale slave ack afterward is ignored.
